// File: rtl/data_mem_io.sv
// data_mem_io: data-side memory and memory-mapped I/O stage behind the CPU.
//
// Address map (only alu_rslt[15:0] decoded):
//   alu_rslt[15:12] != 4'hF : word-addressed data RAM. Upper bits alias and bits [1:0]
//                             are ignored.
//   alu_rslt[15:12] == 4'hF : I/O page. Word offset is alu_rslt[3:2]; bits [11:4] alias.
//     0xF000 TXDATA  store pushes wr_data[7:0] into the TX FIFO; load returns 0
//     0xF004 STATUS  {occupancy at [8 +: PtrW+1], empty at bit1, full at bit0}; stores ignored
//     0xF008 CYCLES  free-running cycle counter; a store loads it
//     0xF00C DROPS   16-bit saturating count of pushes lost to a full FIFO; any store clears it
//
// Build option: define DATA_MEM_IO_CYCLE_COUNTER_EN to implement the CYCLES counter.
// When it is undefined, no counter flops are built, CYCLES reads 0 and stores to it are ignored.
module data_mem_io #(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_rslt,
  input  logic [31:0] wr_data,
  input  logic        mem_write,
  input  logic        mem_reg,
  output logic [31:0] data_to_wr,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);

  localparam logic [PtrW:0]   FullCnt = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [PtrW:0]   CntOne  = (PtrW + 1)'(1);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

  localparam logic [1:0] OffTxData = 2'd0;
  localparam logic [1:0] OffStatus = 2'd1;
  localparam logic [1:0] OffCycles = 2'd2;
  localparam logic [1:0] OffDrops  = 2'd3;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic             io_sel;
  logic [1:0]       io_off;
  logic [AddrW-1:0] ram_idx;
  logic             ram_we;
  logic             io_we;
  logic             push;
  logic             drops_clr;
  logic             cycles_we;

  assign io_sel  = (alu_rslt[15:12] == 4'hF);
  assign io_off  = alu_rslt[3:2];
  assign ram_idx = alu_rslt[AddrW+1:2];

  // RAM writes are not gated by reset; I/O side effects are.
  assign ram_we    = mem_write & ~io_sel;
  assign io_we     = mem_write & io_sel & ~rst;
  assign push      = io_we & (io_off == OffTxData);
  assign cycles_we = io_we & (io_off == OffCycles);
  assign drops_clr = io_we & (io_off == OffDrops);

  // Address bits that take no part in any decode.
  logic unused_addr;
  assign unused_addr = ^{alu_rslt[31:16], alu_rslt[11:4], alu_rslt[1:0]};

  // ---------------------------------------------------------------------------
  // Data RAM: asynchronous read, full-word synchronous write, never cleared
  // ---------------------------------------------------------------------------
  logic [31:0] ram_q [DEPTH];
  logic [31:0] ram_rdata;

  assign ram_rdata = ram_q[ram_idx];

  // Word store on the rising edge.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[ram_idx] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]      fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   fifo_cnt_q, fifo_cnt_d;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;
  logic            push_ok;
  logic            push_drop;

  assign fifo_full  = (fifo_cnt_q == FullCnt);
  assign fifo_empty = (fifo_cnt_q == '0);
  assign tx_valid   = ~fifo_empty;
  // Masked while empty so the port idles at 0, including straight after reset.
  assign tx_data    = tx_valid ? fifo_q[rd_ptr_q] : 8'h00;

  assign pop       = tx_valid & tx_ready & ~rst;
  // A push into a full FIFO still fits when the head leaves in the same cycle.
  assign push_ok   = push & (~fifo_full | pop);
  assign push_drop = push & fifo_full & ~pop;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
    unique case ({push_ok, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CntOne;
      2'b01:   fifo_cnt_d = fifo_cnt_q - CntOne;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Pointer and occupancy state; reset flushes the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Byte storage; when full with a pop, wr_ptr equals rd_ptr and the head is read first.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_q[wr_ptr_q] <= wr_data[7:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Dropped-push counter (saturating)
  // ---------------------------------------------------------------------------
  logic [15:0] drops_q, drops_d;

  // Clear wins over increment; both cannot be requested in one cycle anyway.
  always_comb begin
    drops_d = drops_q;
    if (drops_clr) begin
      drops_d = 16'h0000;
    end else if (push_drop && (drops_q != 16'hFFFF)) begin
      drops_d = drops_q + 16'd1;
    end
  end

  // Dropped-push counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      drops_q <= 16'h0000;
    end else begin
      drops_q <= drops_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Cycle counter
  // ---------------------------------------------------------------------------
  logic [31:0] cycles_rdata;

`ifdef DATA_MEM_IO_CYCLE_COUNTER_EN
  logic [31:0] cycles_q, cycles_d;

  // A store replaces the increment for that cycle.
  always_comb begin
    cycles_d = cycles_we ? wr_data : (cycles_q + 32'd1);
  end

  // Cycle counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycles_q <= 32'h0000_0000;
    end else begin
      cycles_q <= cycles_d;
    end
  end

  assign cycles_rdata = cycles_q;
`else
  logic unused_cycles_we;
  assign unused_cycles_we = cycles_we;
  assign cycles_rdata     = 32'h0000_0000;
`endif

  // ---------------------------------------------------------------------------
  // Load path and write-back mux
  // ---------------------------------------------------------------------------
  logic [31:0] status;
  logic [31:0] io_rdata;
  logic [31:0] load_value;

  // STATUS word assembly.
  always_comb begin
    status                 = '0;
    status[8 +: PtrW + 1]  = fifo_cnt_q;
    status[1]              = fifo_empty;
    status[0]              = fifo_full;
  end

  // I/O page read mux.
  always_comb begin
    io_rdata = '0;
    unique case (io_off)
      OffTxData: io_rdata = 32'h0000_0000;
      OffStatus: io_rdata = status;
      OffCycles: io_rdata = cycles_rdata;
      OffDrops:  io_rdata = {16'h0000, drops_q};
      default:   io_rdata = 32'h0000_0000;
    endcase
  end

  // Combinational write-back selection.
  always_comb begin
    load_value = io_sel ? io_rdata : ram_rdata;
    data_to_wr = mem_reg ? load_value : alu_rslt;
  end

endmodule
